draw_sequencer: RTL and testbench
=================================

// Module: draw_sequencer
// PURPOSE
// - Raster controller for the game datapath: accepts one draw command at a time and walks it pixel by pixel.
// - Command kinds: black clear, full-screen ROM image, or 40x40 sprite ROM image.
// - Per pixel it generates the ROM address, the ROM select and the VGA x/y.
// - Emits a plot strobe aligned to ROM read latency, so the datapath colour mux and VGA adapter stay dumb.
// - Sits between the game FSM (requester) and the ROM bank / colour mux / VGA adapter.
// PARAMETERS
// - SCREEN_W     160  full-screen width in pixels
// - SCREEN_H     120  full-screen height in pixels
// - SPRITE_W     40   sprite width in pixels
// - SPRITE_H     40   sprite height in pixels
// - ROM_LATENCY  1    clocks from address to valid ROM q (range 1..3)
// PORTS
// - clk          in   1   system clock
// - resetn       in   1   asynchronous, active-low reset
// - cmd_valid    in   1   command request
// - cmd_ready    out  1   high only in IDLE; command accepted when cmd_valid && cmd_ready
// - cmd_kind     in   2   0=CLEAR, 1=SCREEN, 2=SPRITE, 3=reserved (accepted, treated as CLEAR)
// - cmd_sel      in   7   ROM select, latched at accept
// - cmd_x        in   8   sprite origin x, latched at accept (ignored for CLEAR/SCREEN)
// - cmd_y        in   7   sprite origin y, latched at accept (ignored for CLEAR/SCREEN)
// - abort        in   1   synchronous cancel of the command in progress
// - screen_addr  out  15  full-screen ROM address (y*SCREEN_W + x)
// - sprite_addr  out  11  sprite ROM address (dy*SPRITE_W + dx)
// - mem_sel      out  7   latched cmd_sel, held stable for the whole command
// - x            out  8   VGA x, aligned with plot
// - y            out  7   VGA y, aligned with plot
// - black        out  1   force colour to 0, aligned with plot (CLEAR only)
// - plot         out  1   VGA write enable
// - busy         out  1   high from accept until done
// - done         out  1   one-cycle pulse when a command completes
// BEHAVIOUR
// - Reset values: all outputs 0, except cmd_ready = 1; state IDLE.
// - States: IDLE -> SETUP -> DRAW -> FLUSH -> DONE -> IDLE.
// - IDLE: on accept, latch kind/sel/x/y and go to SETUP.
// - SETUP: 1 cycle; clear the dx/dy/address counters; mem_sel becomes valid.
// - DRAW: issue one address per cycle, dx fastest.
//   - Row end (dx = W-1): dx -> 0, dy++.
//   - Last pixel (dx = W-1 and dy = H-1): go to FLUSH.
//   - W/H = SCREEN_* for CLEAR/SCREEN, SPRITE_* for SPRITE.
// - Address counters:
//   - screen_addr increments by 1 per issued pixel during CLEAR/SCREEN; last value 19199.
//   - sprite_addr increments by 1 per issued pixel during SPRITE; last value 1599.
//   - Both hold their value outside DRAW.
// - Pipeline: x, y, black and plot go through a ROM_LATENCY-deep delay line.
//   - plot for pixel n is high exactly ROM_LATENCY cycles after its address.
// - FLUSH: ROM_LATENCY cycles, draining the delay line. DONE: done = 1 for 1 cycle.
// - busy = (state != IDLE).
// - Total latency, accept edge to done high: 2 + W*H + ROM_LATENCY cycles.
// - Pixel coordinates: x = base_x + dx, y = base_y + dy; base is 0 for CLEAR/SCREEN.
// - Clipping: a SPRITE pixel with x > 159 or y > 119 (9-bit/8-bit sum, no wrap) is suppressed.
//   - Suppressed means plot = 0 for that slot; the address still advances.
// - abort in SETUP/DRAW/FLUSH: stop issuing; delay-line plot bits cleared.
//   - plot = 0 from the next cycle; go directly to IDLE; no done pulse.
//   - abort in IDLE/DONE: ignored.
// - cmd_valid while busy: ignored (cmd_ready = 0); the requester holds it.
// - resetn low mid-command: immediate return to reset values; the partial frame is not resumed.
// STRUCTURE
// - Package draw_pkg:
//   - cmd_kind encodings (KIND_CLEAR/SCREEN/SPRITE)
//   - state encoding
//   - SCREEN/SPRITE dimension constants
//   - address widths 15/11
// - Sub-module raster_counter: dx/dy counters with parameterised W/H plus linear address counter.
//   - Inputs: clear, step. Outputs: dx, dy, addr, last.
//   - Instantiated once; W/H selected by latched kind.
// - Top level holds the FSM, command latch, clip compare and latency delay line.
// TESTING
// - SCREEN, sel=5, ROM_LATENCY=1:
//   - 19200 plots; first plot x=0,y=0 at 3 cycles after accept.
//   - Last plot x=159,y=119; done at cycle 19203; mem_sel=5 throughout.
// - SPRITE at (60,40):
//   - 1600 plots; x in 60..99, y in 40..79; sprite_addr 0..1599 in order.
//   - screen_addr unchanged.
// - SPRITE at (140,100):
//   - Exactly 20*20 = 400 plots; none with x > 159 or y > 119.
//   - done still at 2 + 1600 + 1 cycles.
// - CLEAR: 19200 plots, each with black = 1; then SPRITE on the next cycle after done gives black = 0 on all plots.
// - abort on pixel 500 of SCREEN:
//   - No plot after the following cycle; no done pulse.
//   - cmd_ready = 1 one cycle later; a new command is accepted and restarts at address 0.
// - resetn pulsed mid-SPRITE, and cmd_valid held during busy:
//   - Outputs return to reset values asynchronously.
//   - The held command is accepted only once, in IDLE.

Source files
------------

// File: rtl/draw_sequencer_pkg.sv
// draw_pkg: shared constants and types for the draw sequencer slice.
//   - command kind encodings as seen on cmd_kind
//   - FSM state encoding
//   - screen and sprite dimensions, ROM address widths
//   - normaliseKind(): folds the reserved kind onto CLEAR
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 40;

  localparam int SCREEN_ADDR_W = 15;
  localparam int SPRITE_ADDR_W = 11;

  localparam logic [1:0] KIND_CLEAR    = 2'd0;
  localparam logic [1:0] KIND_SCREEN   = 2'd1;
  localparam logic [1:0] KIND_SPRITE   = 2'd2;
  localparam logic [1:0] KIND_RESERVED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DRAW,
    ST_FLUSH,
    ST_DONE
  } drawStateT;

  // The reserved encoding is accepted like any other command but drawn as a clear.
  function automatic logic [1:0] normaliseKind(input logic [1:0] kind);
    return (kind == KIND_RESERVED) ? KIND_CLEAR : kind;
  endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: command channel between the game FSM and the draw sequencer.
//   cmd_valid  requester -> sequencer  command request, held until accepted
//   cmd_ready  sequencer -> requester  high only while the sequencer is idle
//   cmd_kind   requester -> sequencer  CLEAR / SCREEN / SPRITE / reserved
//   cmd_sel    requester -> sequencer  ROM select
//   cmd_x      requester -> sequencer  sprite origin x
//   cmd_y      requester -> sequencer  sprite origin y
//   abort      requester -> sequencer  cancel the command in progress
interface draw_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [6:0] cmd_sel;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic       abort;

  modport master (
    output cmd_valid, cmd_kind, cmd_sel, cmd_x, cmd_y, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_sel, cmd_x, cmd_y, abort,
    output cmd_ready
  );

endinterface

// File: rtl/draw_sequencer_raster.sv
// raster_counter: walks a W x H rectangle, dx fastest, with a linear address.
//   clk, resetn  clock and asynchronous active-low reset
//   clear        zero dx, dy and addr
//   step         advance by one pixel; the counters stop on the last pixel
//   lastDx       W-1 for the rectangle being walked
//   lastDy       H-1 for the rectangle being walked
//   dx, dy       current pixel offset
//   addr         dy*W + dx for the current pixel
//   last         current pixel is the bottom-right one
module raster_counter #(
  parameter int DX_W   = 8,
  parameter int DY_W   = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              step,
  input  logic [DX_W-1:0]   lastDx,
  input  logic [DY_W-1:0]   lastDy,
  output logic [DX_W-1:0]   dx,
  output logic [DY_W-1:0]   dy,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic rowEnd;

  assign rowEnd = (dx == lastDx);
  assign last   = rowEnd && (dy == lastDy);

  // Stepping on the last pixel leaves everything in place so addr keeps
  // showing the final address instead of running one past the end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx   <= '0;
      dy   <= '0;
      addr <= '0;
    end else if (clear) begin
      dx   <= '0;
      dy   <= '0;
      addr <= '0;
    end else if (step && !last) begin
      addr <= addr + 1'b1;
      if (rowEnd) begin
        dx <= '0;
        dy <= dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: accepts one draw command at a time and walks it pixel by pixel,
// producing ROM addresses plus a plot strobe delayed to match ROM read latency.
//   clk, resetn   clock and asynchronous active-low reset
//   cmd           command channel (slave side of draw_sequencer_if)
//   screen_addr   full-screen ROM address, y*160 + x
//   sprite_addr   sprite ROM address, dy*40 + dx
//   mem_sel       ROM select latched at accept
//   x, y          VGA coordinates aligned with plot
//   black         force colour to zero (CLEAR), aligned with plot
//   plot          VGA write enable
//   busy          command in progress
//   done          one-cycle pulse on completion
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  draw_sequencer_if.slave          cmd,
  output logic [SCREEN_ADDR_W-1:0] screen_addr,
  output logic [SPRITE_ADDR_W-1:0] sprite_addr,
  output logic [6:0]               mem_sel,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic                     black,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  drawStateT state, stateNext;

  logic [1:0] kindQ;
  logic [6:0] selQ;
  logic [7:0] baseX;
  logic [6:0] baseY;
  logic [1:0] flushCnt;

  logic accept, abortNow, isSprite, issue, clipped;
  logic [1:0] kindIn;

  logic [7:0]               cntDx, lastDx;
  logic [6:0]               cntDy, lastDy;
  logic [SCREEN_ADDR_W-1:0] cntAddr;
  logic                     cntLast;

  logic [8:0] pixX;
  logic [7:0] pixY;

  logic [SCREEN_ADDR_W-1:0] screenHold;
  logic [SPRITE_ADDR_W-1:0] spriteHold;
  logic screenDrawing, spriteDrawing;

  logic [7:0] xPipe     [ROM_LATENCY];
  logic [6:0] yPipe     [ROM_LATENCY];
  logic       blackPipe [ROM_LATENCY];
  logic       plotPipe  [ROM_LATENCY];

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid && (state == ST_IDLE);
  assign abortNow      = cmd.abort &&
                         ((state == ST_SETUP) || (state == ST_DRAW) || (state == ST_FLUSH));
  assign kindIn        = normaliseKind(cmd.cmd_kind);

  assign isSprite = (kindQ == KIND_SPRITE);
  assign issue    = (state == ST_DRAW);
  assign lastDx   = isSprite ? 8'(SPRITE_W - 1) : 8'(SCREEN_W - 1);
  assign lastDy   = isSprite ? 7'(SPRITE_H - 1) : 7'(SCREEN_H - 1);

  raster_counter #(
    .DX_W   (8),
    .DY_W   (7),
    .ADDR_W (SCREEN_ADDR_W)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == ST_SETUP),
    .step   (issue),
    .lastDx (lastDx),
    .lastDy (lastDy),
    .dx     (cntDx),
    .dy     (cntDy),
    .addr   (cntAddr),
    .last   (cntLast)
  );

  // Sums are one bit wider than the VGA coordinates so a sprite hanging off
  // the right or bottom edge is clipped instead of wrapping to the other side.
  assign pixX    = {1'b0, baseX} + {1'b0, cntDx};
  assign pixY    = {1'b0, baseY} + {1'b0, cntDy};
  assign clipped = isSprite && ((pixX > 9'(SCREEN_W - 1)) || (pixY > 8'(SCREEN_H - 1)));

  // Each address output follows the counter only while its own kind is drawing,
  // otherwise it shows the last address it issued.
  assign screenDrawing = issue && !isSprite;
  assign spriteDrawing = issue && isSprite;
  assign screen_addr   = screenDrawing ? cntAddr : screenHold;
  assign sprite_addr   = spriteDrawing ? cntAddr[SPRITE_ADDR_W-1:0] : spriteHold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (accept) stateNext = ST_SETUP;
      ST_SETUP: stateNext = ST_DRAW;
      ST_DRAW:  if (cntLast) stateNext = ST_FLUSH;
      ST_FLUSH: if (flushCnt == 2'(ROM_LATENCY - 1)) stateNext = ST_DONE;
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
    if (abortNow) stateNext = ST_IDLE;
  end

  // Command latch; sprite origin is forced to zero for full-screen kinds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kindQ <= KIND_CLEAR;
      selQ  <= '0;
      baseX <= '0;
      baseY <= '0;
    end else if (accept) begin
      kindQ <= kindIn;
      selQ  <= cmd.cmd_sel;
      baseX <= (kindIn == KIND_SPRITE) ? cmd.cmd_x : 8'd0;
      baseY <= (kindIn == KIND_SPRITE) ? cmd.cmd_y : 7'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flushCnt   <= '0;
      screenHold <= '0;
      spriteHold <= '0;
    end else begin
      flushCnt <= (state == ST_FLUSH) ? flushCnt + 1'b1 : 2'd0;
      if (screenDrawing) screenHold <= cntAddr;
      if (spriteDrawing) spriteHold <= cntAddr[SPRITE_ADDR_W-1:0];
    end
  end

  // Delay line matching ROM latency. An abort wipes every in-flight plot bit
  // so nothing from the cancelled command reaches the VGA adapter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        xPipe[i]     <= '0;
        yPipe[i]     <= '0;
        blackPipe[i] <= 1'b0;
        plotPipe[i]  <= 1'b0;
      end
    end else begin
      xPipe[0]     <= pixX[7:0];
      yPipe[0]     <= pixY[6:0];
      blackPipe[0] <= issue && (kindQ == KIND_CLEAR);
      plotPipe[0]  <= issue && !clipped;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        xPipe[i]     <= xPipe[i-1];
        yPipe[i]     <= yPipe[i-1];
        blackPipe[i] <= blackPipe[i-1];
        plotPipe[i]  <= plotPipe[i-1];
      end
      if (abortNow) begin
        for (int i = 0; i < ROM_LATENCY; i++) plotPipe[i] <= 1'b0;
      end
    end
  end

  assign x       = xPipe[ROM_LATENCY-1];
  assign y       = yPipe[ROM_LATENCY-1];
  assign black   = blackPipe[ROM_LATENCY-1];
  assign plot    = plotPipe[ROM_LATENCY-1];
  assign mem_sel = selQ;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: self-checking bench for draw_sequencer. Plot streams are
// compared against a reference list built directly from the raster rules.
module tb_draw_sequencer;
  import draw_pkg::*;

  localparam int ROM_LAT = 1;

  logic        clk    = 1'b0;
  logic        resetn = 1'b1;
  logic [14:0] screenAddr;
  logic [10:0] spriteAddr;
  logic [6:0]  memSel;
  logic [7:0]  pixX;
  logic [6:0]  pixY;
  logic        black, plot, busy, done;

  draw_sequencer_if cmdIf();

  draw_sequencer #(.ROM_LATENCY(ROM_LAT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd         (cmdIf),
    .screen_addr (screenAddr),
    .sprite_addr (spriteAddr),
    .mem_sel     (memSel),
    .x           (pixX),
    .y           (pixY),
    .black       (black),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations from the last command, indexed by cycle label - 1 for per-cycle data.
  int obsX[$], obsY[$], obsBlack[$], obsCycle[$];
  int cycScreen[$], cycSprite[$], cycReady[$], cycBusy[$];
  int doneCycle, doneCount, memSelBad, acceptReady;

  // Reference plots for the last command.
  int expX[$], expY[$], expBlack[$], expCycle[$];
  int expDone;

  // Cycle label c means the interval after the (c-1)th edge following accept,
  // i.e. the value the VGA adapter samples on edge c.
  function automatic void buildModel(input int kind, input int bx, input int by, input int abortCycle);
    int w, h, ox, oy, px, py, cyc, k;
    expX.delete(); expY.delete(); expBlack.delete(); expCycle.delete();
    k  = (kind == 3) ? 0 : kind;
    w  = (k == 2) ? 40 : 160;
    h  = (k == 2) ? 40 : 120;
    ox = (k == 2) ? bx : 0;
    oy = (k == 2) ? by : 0;
    for (int n = 0; n < w * h; n++) begin
      px  = ox + n % w;
      py  = oy + n / w;
      cyc = 2 + n + ROM_LAT;
      if (abortCycle > 0 && cyc > abortCycle) break;
      if (px <= 159 && py <= 119) begin
        expX.push_back(px);
        expY.push_back(py);
        expBlack.push_back(k == 0 ? 1 : 0);
        expCycle.push_back(cyc);
      end
    end
    expDone = (abortCycle > 0) ? -1 : 2 + w * h + ROM_LAT;
  endfunction

  function automatic int streamMismatches();
    int bad = 0;
    int n;
    if (obsX.size() != expX.size()) bad++;
    n = (obsX.size() < expX.size()) ? obsX.size() : expX.size();
    for (int i = 0; i < n; i++) begin
      if (obsX[i] != expX[i] || obsY[i] != expY[i] ||
          obsBlack[i] != expBlack[i] || obsCycle[i] != expCycle[i]) bad++;
    end
    return bad;
  endfunction

  // Issues one command and records what comes out; comparisons live in the test tasks.
  task automatic applyStimulus(input logic [1:0] kind, input logic [6:0] sel,
                               input logic [7:0] bx, input logic [6:0] by,
                               input int abortCycle, input int runCycles, input bit stopAtDone);
    obsX.delete(); obsY.delete(); obsBlack.delete(); obsCycle.delete();
    cycScreen.delete(); cycSprite.delete(); cycReady.delete(); cycBusy.delete();
    doneCycle = -1; doneCount = 0; memSelBad = 0;
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_kind  = kind;
    cmdIf.cmd_sel   = sel;
    cmdIf.cmd_x     = bx;
    cmdIf.cmd_y     = by;
    acceptReady     = int'(cmdIf.cmd_ready);
    @(posedge clk);
    for (int c = 1; c <= runCycles; c++) begin
      @(negedge clk);
      cycScreen.push_back(int'(screenAddr));
      cycSprite.push_back(int'(spriteAddr));
      cycReady.push_back(int'(cmdIf.cmd_ready));
      cycBusy.push_back(int'(busy));
      if (plot) begin
        obsX.push_back(int'(pixX));
        obsY.push_back(int'(pixY));
        obsBlack.push_back(int'(black));
        obsCycle.push_back(c);
      end
      if (c >= 2 && busy && memSel != sel) memSelBad++;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (c == 1) cmdIf.cmd_valid = 1'b0;
      cmdIf.abort = (c == abortCycle);
      if (stopAtDone && done) break;
    end
    cmdIf.abort = 1'b0;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #2;
    checks++; if (cmdIf.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", cmdIf.cmd_ready); end
    checks++; if ({busy, done, plot, black} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, plot, black}); end
    checks++; if ({pixX, pixY, memSel} !== 22'd0) begin errors++; $display("[TB] FAIL reset_xy_sel: got %h expected 0", {pixX, pixY, memSel}); end
    checks++; if ({screenAddr, spriteAddr} !== 26'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", {screenAddr, spriteAddr}); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_screen();
    int bad;
    applyStimulus(2'd1, 7'd5, 8'd0, 7'd0, 0, 19210, 1'b0);
    buildModel(1, 0, 0, 0);
    checks++; if (acceptReady !== 1) begin errors++; $display("[TB] FAIL screen_ready: got %0d expected 1", acceptReady); end
    checks++; if (obsX.size() !== 19200) begin errors++; $display("[TB] FAIL screen_plots: got %0d expected 19200", obsX.size()); end
    checks++; if (obsCycle.size() == 0 || obsCycle[0] !== 3 || obsX[0] !== 0 || obsY[0] !== 0) begin
      errors++; $display("[TB] FAIL screen_first_plot: got %0d plots, first cycle %0d expected cycle 3 at 0,0", obsCycle.size(), obsCycle.size() ? obsCycle[0] : -1); end
    checks++; if (obsX.size() == 0 || obsX[$] !== 159 || obsY[$] !== 119) begin
      errors++; $display("[TB] FAIL screen_last_plot: got %0d,%0d expected 159,119", obsX.size() ? obsX[$] : -1, obsY.size() ? obsY[$] : -1); end
    checks++; if (doneCycle !== expDone || doneCount !== 1) begin errors++; $display("[TB] FAIL screen_done: got cycle %0d count %0d expected cycle %0d count 1", doneCycle, doneCount, expDone); end
    checks++; if (memSelBad !== 0) begin errors++; $display("[TB] FAIL screen_mem_sel: got %0d bad cycles expected 0", memSelBad); end
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL screen_stream: got %0d mismatches expected 0", bad); end
    checks++; if (cycScreen[1] !== 0 || cycScreen[19200] !== 19199 || cycScreen[19209] !== 19199) begin
      errors++; $display("[TB] FAIL screen_addr: got %0d/%0d/%0d expected 0/19199/19199", cycScreen[1], cycScreen[19200], cycScreen[19209]); end
  endtask

  task automatic test_sprite_inside();
    int bad, badAddr, badScreen;
    logic [6:0] sel;
    sel = 7'($urandom_range(0, 127));
    applyStimulus(2'd2, sel, 8'd60, 7'd40, 0, 1610, 1'b0);
    buildModel(2, 60, 40, 0);
    checks++; if (obsX.size() !== 1600) begin errors++; $display("[TB] FAIL sprite_plots: got %0d expected 1600", obsX.size()); end
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL sprite_stream: got %0d mismatches expected 0", bad); end
    badAddr = 0;
    for (int n = 0; n < 1600; n++) if (cycSprite[n + 1] != n) badAddr++;
    checks++; if (badAddr !== 0) begin errors++; $display("[TB] FAIL sprite_addr_order: got %0d bad addresses expected 0", badAddr); end
    badScreen = 0;
    foreach (cycScreen[i]) if (cycScreen[i] != 19199) badScreen++;
    checks++; if (badScreen !== 0) begin errors++; $display("[TB] FAIL sprite_screen_hold: got %0d changed cycles expected 0", badScreen); end
    checks++; if (doneCycle !== 1603) begin errors++; $display("[TB] FAIL sprite_done: got %0d expected 1603", doneCycle); end
    checks++; if (memSelBad !== 0) begin errors++; $display("[TB] FAIL sprite_mem_sel: got %0d bad cycles expected 0", memSelBad); end
  endtask

  task automatic test_sprite_clip();
    int bad, outside;
    applyStimulus(2'd2, 7'd17, 8'd140, 7'd100, 0, 1610, 1'b0);
    buildModel(2, 140, 100, 0);
    checks++; if (obsX.size() !== 400) begin errors++; $display("[TB] FAIL clip_plots: got %0d expected 400", obsX.size()); end
    outside = 0;
    foreach (obsX[i]) if (obsX[i] > 159 || obsY[i] > 119) outside++;
    checks++; if (outside !== 0) begin errors++; $display("[TB] FAIL clip_outside: got %0d expected 0", outside); end
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL clip_stream: got %0d mismatches expected 0", bad); end
    checks++; if (doneCycle !== 1603) begin errors++; $display("[TB] FAIL clip_done: got %0d expected 1603", doneCycle); end
  endtask

  task automatic test_random_sprites();
    int bad, bx, by;
    for (int t = 0; t < 3; t++) begin
      bx = $urandom_range(0, 255);
      by = $urandom_range(0, 127);
      applyStimulus(2'd2, 7'($urandom_range(0, 127)), 8'(bx), 7'(by), 0, 1610, 1'b0);
      buildModel(2, bx, by, 0);
      bad = streamMismatches();
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rand_sprite_stream(%0d,%0d): got %0d mismatches, %0d plots expected %0d", bx, by, bad, obsX.size(), expX.size()); end
      checks++; if (doneCycle !== expDone || doneCount !== 1) begin errors++; $display("[TB] FAIL rand_sprite_done: got %0d count %0d expected %0d", doneCycle, doneCount, expDone); end
    end
  endtask

  task automatic test_back_to_back();
    int bad, notBlack, isBlack, bx, by;
    applyStimulus(2'd0, 7'd1, 8'd0, 7'd0, 0, 19210, 1'b1);
    buildModel(0, 0, 0, 0);
    notBlack = 0;
    foreach (obsBlack[i]) if (obsBlack[i] != 1) notBlack++;
    checks++; if (obsX.size() !== 19200 || notBlack !== 0) begin errors++; $display("[TB] FAIL clear_black: got %0d plots, %0d not black expected 19200, 0", obsX.size(), notBlack); end
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL clear_stream: got %0d mismatches expected 0", bad); end
    checks++; if (doneCycle !== 19203) begin errors++; $display("[TB] FAIL clear_done: got %0d expected 19203", doneCycle); end
    bx = $urandom_range(0, 120);
    by = $urandom_range(0, 80);
    applyStimulus(2'd2, 7'd2, 8'(bx), 7'(by), 0, 1610, 1'b0);
    buildModel(2, bx, by, 0);
    checks++; if (acceptReady !== 1) begin errors++; $display("[TB] FAIL b2b_ready: got %0d expected 1", acceptReady); end
    isBlack = 0;
    foreach (obsBlack[i]) if (obsBlack[i] != 0) isBlack++;
    checks++; if (isBlack !== 0) begin errors++; $display("[TB] FAIL b2b_black: got %0d black plots expected 0", isBlack); end
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL b2b_stream: got %0d mismatches expected 0", bad); end
  endtask

  task automatic test_abort();
    int bad;
    // Pixel 500 is addressed in cycle 2 + 500.
    applyStimulus(2'd1, 7'd9, 8'd0, 7'd0, 502, 560, 1'b0);
    buildModel(1, 0, 0, 502);
    checks++; if (obsX.size() !== 500) begin errors++; $display("[TB] FAIL abort_plots: got %0d expected 500", obsX.size()); end
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL abort_stream: got %0d mismatches expected 0", bad); end
    checks++; if (doneCount !== 0) begin errors++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", doneCount); end
    checks++; if (cycReady[502] !== 1 || cycBusy[502] !== 0) begin errors++; $display("[TB] FAIL abort_idle: got ready %0d busy %0d expected 1 0", cycReady[502], cycBusy[502]); end
    applyStimulus(2'd1, 7'd9, 8'd0, 7'd0, 20, 30, 1'b0);
    buildModel(1, 0, 0, 20);
    checks++; if (acceptReady !== 1 || cycScreen[1] !== 0 || cycScreen[2] !== 1) begin
      errors++; $display("[TB] FAIL abort_restart: got ready %0d addr %0d,%0d expected 1 0,1", acceptReady, cycScreen[1], cycScreen[2]); end
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL abort_restart_stream: got %0d mismatches expected 0", bad); end
  endtask

  task automatic test_reserved_kind();
    int bad;
    applyStimulus(2'd3, 7'd44, 8'd77, 7'd33, 100, 110, 1'b0);
    buildModel(3, 77, 33, 100);
    bad = streamMismatches();
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL reserved_stream: got %0d mismatches, %0d plots expected %0d", bad, obsX.size(), expX.size()); end
  endtask

  task automatic test_reset_mid_sprite();
    int accepts = 0;
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd_kind  = 2'd2;
    cmdIf.cmd_sel   = 7'd3;
    cmdIf.cmd_x     = 8'd10;
    cmdIf.cmd_y     = 7'd10;
    for (int c = 0; c < 200; c++) begin
      if (cmdIf.cmd_valid && cmdIf.cmd_ready) accepts++;
      @(negedge clk);
    end
    checks++; if (accepts !== 1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL held_valid: got %0d accepts busy %b expected 1 accept busy 1", accepts, busy); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || plot !== 1'b0 || cmdIf.cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_flags: got busy %b plot %b ready %b done %b expected 0 0 1 0", busy, plot, cmdIf.cmd_ready, done); end
    checks++; if ({spriteAddr, memSel, pixX, pixY} !== 33'd0) begin errors++; $display("[TB] FAIL midreset_values: got %h expected 0", {spriteAddr, memSel, pixX, pixY}); end
    cmdIf.cmd_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || cmdIf.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_resume: got busy %b ready %b expected 0 1", busy, cmdIf.cmd_ready); end
  endtask

  initial begin
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_kind  = 2'd0;
    cmdIf.cmd_sel   = 7'd0;
    cmdIf.cmd_x     = 8'd0;
    cmdIf.cmd_y     = 7'd0;
    cmdIf.abort     = 1'b0;
    $display("[TB] draw_sequencer bench starting");
    test_reset();
    test_screen();
    test_sprite_inside();
    test_sprite_clip();
    test_random_sprites();
    test_back_to_back();
    test_abort();
    test_reserved_kind();
    test_reset_mid_sprite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
